// File: rtl/mem_pkg.sv
// Shared memory parameters for the main memory and the cache controller.
//   ADDR_W        : byte address width seen on the bus
//   MEM_DATA_W    : default width of one storage location (one byte)
//   MEM_ADDR_BITS : default number of low address bits decoded
package mem_pkg;
  localparam int ADDR_W        = 32;
  localparam int MEM_DATA_W    = 8;
  localparam int MEM_ADDR_BITS = 10;
endpackage

// File: rtl/main_memory_if.sv
// Bus between a memory master (cache controller / bench) and main_memory.
//   Address    : byte address, read and write
//   Data       : write data
//   ismemWrite : write enable, sampled on rising clk
//   outputmem  : combinational read data for Address
interface main_memory_if
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
);
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Data;
  logic              ismemWrite;
  logic [DATA_W-1:0] outputmem;

  modport master (output Address, Data, ismemWrite, input outputmem);
  modport slave  (input Address, Data, ismemWrite, output outputmem);
endinterface

// File: rtl/main_memory_array.sv
// Storage array: async clear, one synchronous write port, one combinational
// read port sharing the same index.
//   clk, rst : clock, async active-high clear of every location
//   we       : write strobe (already qualified by the wrapper)
//   addr     : location index for both read and write
//   wdata    : write data
//   rdata    : mem[addr], no latency
module main_memory_array #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Clear is level-sensitive through the async branch: edges during rst
  // re-enter the clear branch, so writes during reset are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem       <= '0;
    else if (we) mem[addr] <= wdata;
  end

  // No bypass: a location being written shows old data until the edge.
  assign rdata = mem[addr];
endmodule

// File: rtl/main_memory.sv
// Byte-addressed main memory. Upper address bits are ignored so addresses
// alias modulo 2^ADDR_BITS. Reads are combinational, writes on rising clk.
//   clk, rst : clock, async active-high reset (clears all contents)
//   bus      : slave side of main_memory_if (Address, Data, ismemWrite,
//              outputmem)
module main_memory
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int DATA_W    = MEM_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  main_memory_if.slave  bus
);
  logic [ADDR_BITS-1:0] idx;
  logic                 we;
  logic                 unused_addr_hi;

  assign idx            = bus.Address[ADDR_BITS-1:0];
  assign unused_addr_hi = ^bus.Address[ADDR_W-1:ADDR_BITS];

  // Only a clean 1 writes; X/Z in an if() condition is taken as false.
  assign we = (bus.ismemWrite == 1'b1) && !rst;

  main_memory_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .addr  (idx),
    .wdata (bus.Data),
    .rdata (bus.outputmem)
  );
endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  main_memory_if #(.DATA_W(8)) bus ();

  main_memory #(.ADDR_BITS(10), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;   // posedges at 5, 15, 25, ...

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input logic [31:0] a, input logic [7:0] d, input logic w,
                     input logic [7:0] e, input string nm);
    vecs[nv].addr = a; vecs[nv].data = d; vecs[nv].we = w;
    vecs[nv].exp  = e; vecs[nv].name = nm;
    nv++;
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  initial begin
    bus.Address = '0; bus.Data = '0; bus.ismemWrite = 1'b0;

    // Reset asserted after time 0 so the async edge is seen.
    #3 rst = 1'b1;
    #1 check("reset_read", bus.outputmem, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Post-reset sweep: every location reads zero.
    begin
      int bad = 0;
      for (int a = 0; a < 1024; a++) begin
        bus.Address = a;
        #1;
        n_chk++;
        if (bus.outputmem !== 8'h00) begin
          bad++;
          n_fail++;
          if (bad < 4) $display("FAIL sweep addr %0d: got %02h expected 00", a, bus.outputmem);
        end
      end
    end

    // Directed vectors: writes are clocked on consecutive edges, reads
    // settle combinationally with no edge required.
    add(32'h0000_0010, 8'hA5, 1'b1, 8'hA5, "wr_10");
    add(32'h0000_0011, 8'h00, 1'b0, 8'h00, "rd_11_neighbor");
    add(32'h0000_0010, 8'h00, 1'b0, 8'hA5, "rd_10");
    for (int i = 0; i < 8; i++) add(32'h40 + i, 8'h10 + i[7:0], 1'b1, 8'h10 + i[7:0], "line_wr");
    for (int i = 0; i < 8; i++) add(32'h40 + i, 8'h00, 1'b0, 8'h10 + i[7:0], "line_rd");
    add(32'h0000_0005, 8'h3C, 1'b1, 8'h3C, "wr_05");
    add(32'hFFFF_FC05, 8'h00, 1'b0, 8'h3C, "alias_rd_FC05");
    add(32'h0000_0405, 8'h77, 1'b1, 8'h77, "alias_wr_405");
    add(32'h0000_0005, 8'h00, 1'b0, 8'h77, "alias_rd_05");
    add(32'h0000_0050, 8'h01, 1'b1, 8'h01, "b2b_wr1");
    add(32'h0000_0050, 8'h02, 1'b1, 8'h02, "b2b_wr2");
    add(32'h0000_0050, 8'h00, 1'b0, 8'h02, "b2b_rd");
    add(32'h0000_0020, 8'h11, 1'b1, 8'h11, "wr_20");

    @(negedge clk);
    for (int i = 0; i < nv; i++) begin
      bus.Address    = vecs[i].addr;
      bus.Data       = vecs[i].data;
      bus.ismemWrite = vecs[i].we;
      if (vecs[i].we) begin
        @(posedge clk);
        #1;
      end else begin
        #1;
      end
      check(vecs[i].name, bus.outputmem, vecs[i].exp);
    end
    bus.ismemWrite = 1'b0;

    // Write disabled: clock runs with Data=FF, contents hold.
    bus.Address = 32'h20; bus.Data = 8'hFF;
    repeat (3) @(posedge clk);
    #1 check("hold_no_we", bus.outputmem, 8'h11);

    // No bypass: old data before the edge, new data after.
    @(negedge clk);
    bus.Address = 32'h30; bus.Data = 8'h5A; bus.ismemWrite = 1'b1;
    #1 check("pre_edge_old", bus.outputmem, 8'h00);
    @(posedge clk);
    #1 check("post_edge_new", bus.outputmem, 8'h5A);
    bus.ismemWrite = 1'b0;

    // Mid-cycle async reset clears immediately, then blocks writes.
    @(negedge clk);
    bus.Address = 32'h08; bus.Data = 8'h99; bus.ismemWrite = 1'b1;
    @(posedge clk);
    #1 check("wr_08", bus.outputmem, 8'h99);
    bus.ismemWrite = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_clr_08", bus.outputmem, 8'h00);
    bus.Address = 32'h10;
    #0.5 check("async_clr_10", bus.outputmem, 8'h00);
    bus.Address = 32'h08; bus.Data = 8'h55; bus.ismemWrite = 1'b1;
    @(posedge clk);
    #1 check("wr_during_rst", bus.outputmem, 8'h00);
    bus.ismemWrite = 1'b0;
    bus.Address = 32'h45;
    #1 check("line_cleared", bus.outputmem, 8'h00);

    // First edge after reset release accepts a write.
    @(negedge clk) rst = 1'b0;
    bus.Address = 32'h08; bus.Data = 8'h66; bus.ismemWrite = 1'b1;
    @(posedge clk);
    #1 check("first_wr_after_rst", bus.outputmem, 8'h66);
    bus.ismemWrite = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, number of low address bits decoded (2^ADDR_BITS bytes of storage).
REQ-002 SHALL have parameter DATA_W, default 8, width of one storage location in bits (one byte).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all writes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port Address, input, 32 bits, byte address for both read and write.
REQ-006 SHALL have port Data, input, DATA_W bits, write data.
REQ-007 SHALL have port ismemWrite, input, 1 bit, write enable; 1 = write Data at Address on the next rising clk edge.
REQ-008 SHALL have port outputmem, output, DATA_W bits, read data for Address.

Function
REQ-009 Storage SHALL be 2^ADDR_BITS locations of DATA_W bits, indexed by Address[ADDR_BITS-1:0].
REQ-010 Address[31:ADDR_BITS] SHALL be ignored; addresses alias modulo 2^ADDR_BITS; no error is raised.
REQ-011 Read SHALL be combinational, zero latency: outputmem = mem[Address[ADDR_BITS-1:0]] at all times.
REQ-012 outputmem SHALL update in the same delta/cycle as any change of Address or of the addressed location, with no clock required.
REQ-013 Write SHALL occur on rising clk when ismemWrite=1 and rst=0: mem[Address[ADDR_BITS-1:0]] <= Data.
REQ-014 With ismemWrite=0 the memory SHALL hold all contents unchanged.
REQ-015 Same-cycle read of a location being written SHALL return old data before the edge and new data after it; there is no write-through bypass.
REQ-016 Back-to-back writes on consecutive cycles to any addresses, including the same address, SHALL each complete; the last write wins.
REQ-017 Only one write per clock edge SHALL be possible; there is no byte enable and no burst mode.
REQ-018 X/Z on ismemWrite SHALL be treated as no write.

Reset
REQ-019 While rst=1, every location SHALL be cleared to 0 asynchronously, and outputmem SHALL read 0 for every Address.
REQ-020 Writes SHALL be ignored while rst=1; a write edge coinciding with rst assertion is discarded.
REQ-021 After rst deasserts, the first rising clk SHALL accept a write normally.
REQ-022 Reset asserted mid-sequence SHALL discard all prior contents; there is no partial retention.

Structure
REQ-023 Package mem_pkg SHALL hold ADDR_W=32, the DATA_W default and the ADDR_BITS default, shared with the cache controller.
REQ-024 One sub-module main_memory_array SHALL hold the storage array, with async clear, synchronous write port and combinational read port; main_memory wraps it with address truncation and enable qualification.

Verification
REQ-025 Reset, then sweep Address over 0..1023 -> outputmem = 0x00 for every address.
REQ-026 Write 0xA5 to 0x0000_0010, then read 0x0000_0010 -> 0xA5; read 0x0000_0011 -> 0x00.
REQ-027 Write bytes 0x10..0x17 to 0x40..0x47 (one 8-byte cache line) on consecutive cycles -> read back 0x10..0x17 in order, with no clock needed between reads.
REQ-028 Write 0x3C to 0x0000_0005, then read 0xFFFF_FC05 -> 0x3C (aliasing); write 0x77 to 0x0000_0405 -> reading 0x0000_0005 returns 0x77.
REQ-029 With ismemWrite=0, Data=0xFF and clk toggling at 0x20 (holding 0x11) -> outputmem stays 0x11.
REQ-030 Write 0x99 to 0x08, then assert rst asynchronously mid-cycle -> outputmem at 0x08 becomes 0x00 immediately, before any clk edge; a write attempted during rst leaves 0x00.
